// File: rtl/hls_ctrl_pkg.sv
// Shared definitions for the HLS run controller.
// Holds the result status codes, the controller state encoding and the
// result record layout: {status[STATUS_W-1:0], cycles[CNT_W-1:0]}.
package hls_ctrl_pkg;

    localparam int STATUS_W = 2;

    localparam logic [STATUS_W-1:0] ST_OK      = 2'b00;
    localparam logic [STATUS_W-1:0] ST_TIMEOUT = 2'b01;
    localparam logic [STATUS_W-1:0] ST_ABORTED = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRST,
        S_START,
        S_WAIT,
        S_LOG,
        S_FIN
    } state_t;

    // Width of one result record for a given counter width.
    function automatic int rec_w(input int cnt_w);
        return STATUS_W + cnt_w;
    endfunction

endpackage

// File: rtl/hls_result_fifo.sv
// Synchronous result FIFO with first-word-fall-through output.
// Ports:
//   clock, reset (async, active-low)
//   push/wdata : write side; a write while full is taken only with a pop
//   pop        : consumer pop, ignored when empty
//   rdata      : head entry (valid when !empty)
//   empty/full : occupancy flags
module hls_result_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 34
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             count;
    logic                    pop_ok;
    logic                    wr_en;

    assign empty  = (count == '0);
    assign full   = (count == (AW+1)'(DEPTH));
    assign pop_ok = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en  = push && (!full || pop_ok);
    assign rdata  = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hls_run_controller.sv
// Run controller for a Bambu-generated kernel.
// Resets the kernel, pulses start, counts cycles to done (with timeout),
// repeats for num_runs runs, logs {status, cycles} per run into a result
// FIFO and keeps min/max/saturating-total statistics over OK runs.
// Ports:
//   clock, reset (async, active-low)
//   go, abort, num_runs          : campaign control
//   dut_reset, dut_start_port    : kernel control (registered)
//   dut_done_port                : kernel completion pulse
//   res_valid/res_ready/res_data : result FIFO read side
//   busy, campaign_done          : campaign status (registered)
//   min/max/total_cycles         : statistics over OK runs
module hls_run_controller
    import hls_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int RUN_W       = 8,
    parameter int TIMEOUT_CYC = 200000000,
    parameter int DUT_RST_CYC = 2,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      go,
    input  logic                      abort,
    input  logic [RUN_W-1:0]          num_runs,
    output logic                      dut_reset,
    output logic                      dut_start_port,
    input  logic                      dut_done_port,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [STATUS_W+CNT_W-1:0] res_data,
    output logic                      busy,
    output logic                      campaign_done,
    output logic [CNT_W-1:0]          min_cycles,
    output logic [CNT_W-1:0]          max_cycles,
    output logic [CNT_W-1:0]          total_cycles
);

    localparam int DW = (DUT_RST_CYC > 1) ? $clog2(DUT_RST_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYC);
    localparam logic [DW-1:0]    DRST_LAST = DW'(DUT_RST_CYC - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DW-1:0]         dcnt_q, dcnt_d;
    logic [RUN_W-1:0]      runs_q, runs_d;
    logic [STATUS_W-1:0]   rec_st_q, rec_st_d;
    logic [CNT_W-1:0]      rec_cyc_q, rec_cyc_d;
    logic [CNT_W-1:0]      min_d, max_d, total_d;
    logic [CNT_W:0]        sum;
    logic                  push;
    logic                  can_push;
    logic                  fifo_empty;
    logic                  fifo_full;

    assign can_push  = !fifo_full || (res_ready && !fifo_empty);
    assign res_valid = !fifo_empty;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dcnt_d    = dcnt_q;
        runs_d    = runs_q;
        rec_st_d  = rec_st_q;
        rec_cyc_d = rec_cyc_q;
        min_d     = min_cycles;
        max_d     = max_cycles;
        total_d   = total_cycles;
        push      = 1'b0;
        sum       = {1'b0, total_cycles} + {1'b0, rec_cyc_q};

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    runs_d  = (num_runs == '0) ? RUN_W'(1) : num_runs;
                    min_d   = '1;
                    max_d   = '0;
                    total_d = '0;
                    dcnt_d  = '0;
                    cnt_d   = '0;
                    state_d = S_DRST;
                end
            end
            S_DRST: begin
                if (abort) begin
                    rec_st_d  = ST_ABORTED;
                    rec_cyc_d = cnt_q;
                    state_d   = S_LOG;
                end else if (dcnt_q == DRST_LAST) begin
                    state_d = S_START;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            S_START: begin
                // The start cycle itself counts as cycle 1.
                cnt_d = CNT_W'(1);
                if (abort) begin
                    rec_st_d  = ST_ABORTED;
                    rec_cyc_d = CNT_W'(1);
                    state_d   = S_LOG;
                end else if (dut_done_port) begin
                    rec_st_d  = ST_OK;
                    rec_cyc_d = CNT_W'(1);
                    state_d   = S_LOG;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // done is checked before the limit so a done on the limit
                // cycle is still reported OK.
                if (abort) begin
                    rec_st_d  = ST_ABORTED;
                    rec_cyc_d = cnt_q;
                    state_d   = S_LOG;
                end else if (dut_done_port) begin
                    rec_st_d  = ST_OK;
                    rec_cyc_d = cnt_q + CNT_W'(1);
                    state_d   = S_LOG;
                end else if (cnt_q == TO_VAL) begin
                    rec_st_d  = ST_TIMEOUT;
                    rec_cyc_d = TO_VAL;
                    state_d   = S_LOG;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOG: begin
                push = 1'b1;
                if (can_push) begin
                    if (rec_st_q == ST_OK) begin
                        min_d   = (rec_cyc_q < min_cycles) ? rec_cyc_q : min_cycles;
                        max_d   = (rec_cyc_q > max_cycles) ? rec_cyc_q : max_cycles;
                        total_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
                        runs_d  = runs_q - RUN_W'(1);
                        if (abort || runs_q == RUN_W'(1)) begin
                            state_d = S_FIN;
                        end else begin
                            dcnt_d  = '0;
                            cnt_d   = '0;
                            state_d = S_DRST;
                        end
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            dcnt_q         <= '0;
            runs_q         <= '0;
            rec_st_q       <= '0;
            rec_cyc_q      <= '0;
            min_cycles     <= '1;
            max_cycles     <= '0;
            total_cycles   <= '0;
            dut_reset      <= 1'b0;
            dut_start_port <= 1'b0;
            busy           <= 1'b0;
            campaign_done  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dcnt_q         <= dcnt_d;
            runs_q         <= runs_d;
            rec_st_q       <= rec_st_d;
            rec_cyc_q      <= rec_cyc_d;
            min_cycles     <= min_d;
            max_cycles     <= max_d;
            total_cycles   <= total_d;
            // Outputs are registered from the next state so they line up
            // with the state they describe.
            dut_reset      <= (state_d == S_START) || (state_d == S_WAIT) ||
                              (state_d == S_LOG);
            dut_start_port <= (state_d == S_START);
            busy           <= (state_d != S_IDLE);
            campaign_done  <= (state_d == S_FIN);
        end
    end

    hls_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (rec_w(CNT_W))
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata ({rec_st_q, rec_cyc_q}),
        .pop   (res_ready),
        .rdata (res_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_hls_run_controller.sv
// Directed bench for hls_run_controller: small kernel model answers each
// start pulse after a queued latency; results are collected from the FIFO
// and compared with hand-computed records and statistics.
module tb_hls_run_controller;

    localparam int CNT_W = 32;
    localparam int RUN_W = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              go = 1'b0;
    logic              abort = 1'b0;
    logic [RUN_W-1:0]  num_runs = '0;
    logic              dut_reset;
    logic              dut_start_port;
    logic              dut_done_port = 1'b0;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [CNT_W+1:0]  res_data;
    logic              busy;
    logic              campaign_done;
    logic [CNT_W-1:0]  min_cycles, max_cycles, total_cycles;

    always #5 clock = ~clock;

    hls_run_controller #(
        .CNT_W       (CNT_W),
        .RUN_W       (RUN_W),
        .TIMEOUT_CYC (50),
        .DUT_RST_CYC (2),
        .FIFO_DEPTH  (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .go             (go),
        .abort          (abort),
        .num_runs       (num_runs),
        .dut_reset      (dut_reset),
        .dut_start_port (dut_start_port),
        .dut_done_port  (dut_done_port),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .busy           (busy),
        .campaign_done  (campaign_done),
        .min_cycles     (min_cycles),
        .max_cycles     (max_cycles),
        .total_cycles   (total_cycles)
    );

    int               n_chk = 0;
    int               n_pass = 0;
    int               cd_cnt = 0;
    int               lat_q[$];
    logic [CNT_W+1:0] got_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] rec(input int i);
        logic [63:0] r;
        r = '1;
        if (i < got_q.size()) r = 64'(got_q[i]);
        return r;
    endfunction

    // Handshake and pulse monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (res_valid && res_ready) got_q.push_back(res_data);
        if (campaign_done) cd_cnt++;
    end

    // Kernel model: done arrives lat cycles after the start cycle.
    initial begin
        int kcnt;
        kcnt = -1;
        forever begin
            @(posedge clock);
            #1;
            dut_done_port = 1'b0;
            if (!dut_reset) begin
                kcnt = -1;
            end else begin
                if (kcnt > 0) kcnt--;
                if (kcnt == 0) begin
                    dut_done_port = 1'b1;
                    kcnt = -1;
                end
                if (dut_start_port)
                    kcnt = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic start_campaign(input int n);
        num_runs = RUN_W'(n);
        go = 1'b1;
        step(1);
        go = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (dut_start_port) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        chk(tag, found, 1'b1);
    endtask

    task automatic wait_fin(input string tag, input int budget, output logic dr);
        bit found;
        found = 1'b0;
        dr = 1'bx;
        for (int i = 0; i < budget; i++) begin
            if (campaign_done) begin
                found = 1'b1;
                dr = dut_reset;
                break;
            end
            step(1);
        end
        chk(tag, found, 1'b1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dut_reset"}, dut_reset, 1'b0);
        chk({tag, "_start"}, dut_start_port, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_cdone"}, campaign_done, 1'b0);
        chk({tag, "_res_valid"}, res_valid, 1'b0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_min"}, min_cycles, 32'hFFFF_FFFF);
        chk({tag, "_max"}, max_cycles, 0);
        chk({tag, "_total"}, total_cycles, 0);
    endtask

    initial begin
        logic dr;
        int   c0;

        // Reset state
        step(2);
        chk_reset_vals("rst");
        reset = 1'b1;
        step(1);

        // Single run, done 10 cycles after start -> {OK, 11}
        got_q.delete();
        lat_q = '{10};
        c0 = cd_cnt;
        start_campaign(1);
        chk("t1_busy", busy, 1'b1);
        chk("t1_drst", dut_reset, 1'b0);
        step(1);
        chk("t1_nostart", dut_start_port, 1'b0);
        step(1);
        chk("t1_start_lat", dut_start_port, 1'b1);
        chk("t1_start_rst", dut_reset, 1'b1);
        wait_fin("t1_fin", 100, dr);
        chk("t1_fin_busy", busy, 1'b1);
        step(1);
        chk("t1_idle_busy", busy, 1'b0);
        step(3);
        chk("t1_n", got_q.size(), 1);
        chk("t1_rec", rec(0), 64'({2'b00, 32'd11}));
        chk("t1_min", min_cycles, 11);
        chk("t1_max", max_cycles, 11);
        chk("t1_total", total_cycles, 11);
        chk("t1_cdone", cd_cnt - c0, 1);

        // Three runs, latencies 5, 9, 7
        got_q.delete();
        lat_q = '{5, 9, 7};
        start_campaign(3);
        wait_fin("t2_fin", 300, dr);
        step(4);
        chk("t2_n", got_q.size(), 3);
        chk("t2_rec0", rec(0), 64'({2'b00, 32'd6}));
        chk("t2_rec1", rec(1), 64'({2'b00, 32'd10}));
        chk("t2_rec2", rec(2), 64'({2'b00, 32'd8}));
        chk("t2_min", min_cycles, 6);
        chk("t2_max", max_cycles, 10);
        chk("t2_total", total_cycles, 24);

        // Timeout: no done ever; campaign stops after the first run
        got_q.delete();
        lat_q.delete();
        start_campaign(2);
        wait_fin("t3_fin", 300, dr);
        chk("t3_fin_rst", dr, 1'b0);
        step(4);
        chk("t3_n", got_q.size(), 1);
        chk("t3_rec", rec(0), 64'({2'b01, 32'd50}));
        chk("t3_min", min_cycles, 32'hFFFF_FFFF);
        chk("t3_max", max_cycles, 0);
        chk("t3_total", total_cycles, 0);

        // Back-pressure: depth-2 FIFO, consumer stalled, 4 runs
        got_q.delete();
        res_ready = 1'b0;
        lat_q = '{3, 4, 5, 6};
        start_campaign(4);
        step(60);
        chk("t4_stall_busy", busy, 1'b1);
        chk("t4_stall_n", got_q.size(), 0);
        chk("t4_stall_valid", res_valid, 1'b1);
        res_ready = 1'b1;
        wait_fin("t4_fin", 300, dr);
        step(4);
        chk("t4_n", got_q.size(), 4);
        chk("t4_rec0", rec(0), 64'({2'b00, 32'd4}));
        chk("t4_rec1", rec(1), 64'({2'b00, 32'd5}));
        chk("t4_rec2", rec(2), 64'({2'b00, 32'd6}));
        chk("t4_rec3", rec(3), 64'({2'b00, 32'd7}));
        chk("t4_min", min_cycles, 4);
        chk("t4_max", max_cycles, 7);
        chk("t4_total", total_cycles, 22);

        // Abort during WAIT at counter 20
        got_q.delete();
        lat_q.delete();
        c0 = cd_cnt;
        start_campaign(1);
        wait_start("t5_start");
        step(20);
        abort = 1'b1;
        wait_fin("t5_fin", 50, dr);
        abort = 1'b0;
        step(1);
        chk("t5_busy", busy, 1'b0);
        step(3);
        chk("t5_n", got_q.size(), 1);
        chk("t5_rec", rec(0), 64'({2'b10, 32'd20}));
        chk("t5_cdone", cd_cnt - c0, 1);

        // Reset pulsed during WAIT, then a normal run with num_runs = 0
        got_q.delete();
        lat_q = '{30};
        start_campaign(1);
        wait_start("t6_start");
        step(5);
        reset = 1'b0;
        step(1);
        chk_reset_vals("t6_rst");
        reset = 1'b1;
        step(2);
        chk("t6_n_after_rst", got_q.size(), 0);
        lat_q = '{12};
        c0 = cd_cnt;
        start_campaign(0);
        wait_fin("t6_fin", 100, dr);
        step(4);
        chk("t6_n", got_q.size(), 1);
        chk("t6_rec", rec(0), 64'({2'b00, 32'd13}));
        chk("t6_min", min_cycles, 13);
        chk("t6_max", max_cycles, 13);
        chk("t6_total", total_cycles, 13);
        chk("t6_cdone", cd_cnt - c0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
